// File: rtl/piso_link_pkg.sv
// Shared link definitions for the parallel-in/serial-out transmit path.
// Provides:
//   link_state_e   - link FSM state encoding (WAIT_LOCK / TRAIN / RUN)
//   Type*          - 2-bit word type codes carried in the top of every word
//   train_payload  - generator for the alternating 1010... training payload
package piso_link_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'b00,
        StTrain    = 2'b01,
        StRun      = 2'b10
    } link_state_e;

    localparam logic [1:0] TypeIdle  = 2'b00;
    localparam logic [1:0] TypeTrain = 2'b01;
    localparam logic [1:0] TypeData  = 2'b10;

    localparam int unsigned MaxPayload = 64;

    // Alternating pattern over the low 'width' bits, with a 1 in the MSB
    // position (bit width-1). Bits at and above 'width' are zero.
    function automatic logic [MaxPayload-1:0] train_payload(input int unsigned width);
        logic [MaxPayload-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < MaxPayload; i++) begin
            if (i < width) begin
                pat[i] = ((width - 1 - i) % 2 == 0);
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req  [NREQ]  - request vector
//   i_ptr  [CHW]   - index where the search starts (highest priority)
//   o_gnt  [NREQ]  - one-hot grant, or zero when no request is present
// NREQ is expected to be at least 2.
module rr_arbiter #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned CHW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [CHW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt
);

    localparam int unsigned IW = CHW + 1;

    logic [IW-1:0]  idx_w;
    logic [CHW-1:0] idx;
    logic           found;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        idx_w = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // Modulo-NREQ walk starting at the pointer; works for non-power-of-2 NREQ.
            idx_w = {1'b0, i_ptr} + IW'(i);
            if (idx_w >= IW'(NREQ)) begin
                idx_w = idx_w - IW'(NREQ);
            end
            idx = idx_w[CHW-1:0];
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Transmit scheduler feeding a serializer's parallel word input.
// Qualifies serializer lock, sends a training sequence, then multiplexes
// NREQ requesters onto the link with round-robin arbitration.
// Ports:
//   i_pclk        - parallel clock (all logic on rising edge)
//   i_rst_n       - asynchronous active-low reset
//   i_plock       - serializer parallel-lock indication
//   i_retrain     - single-cycle request to rerun training
//   i_req_valid   - per-requester valid
//   i_req_data    - payloads, requester k at [k*DWIDTH +: DWIDTH]
//   o_req_ready   - one-hot-or-zero grant (combinational)
//   o_pdata       - registered word {type, chan, payload} to the serializer
//   o_link_up     - high only in RUN
//   o_state       - current link state
module piso_tx_sched
    import piso_link_pkg::*;
#(
    parameter int unsigned  PWIDTH      = 20,
    parameter int unsigned  NREQ        = 4,
    parameter int unsigned  LOCK_CYC    = 16,
    parameter int unsigned  TRAIN_WORDS = 32,
    localparam int unsigned CHW         = $clog2(NREQ),
    localparam int unsigned DWIDTH      = PWIDTH - 2 - CHW
) (
    input  logic                   i_pclk,
    input  logic                   i_rst_n,
    input  logic                   i_plock,
    input  logic                   i_retrain,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*DWIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [PWIDTH-1:0]      o_pdata,
    output logic                   o_link_up,
    output logic [1:0]             o_state
);

    localparam int unsigned LCW = $clog2(LOCK_CYC + 1);
    localparam int unsigned TCW = $clog2(TRAIN_WORDS + 1);

    localparam logic [LCW-1:0]        LockLast     = LCW'(LOCK_CYC - 1);
    localparam logic [TCW-1:0]        TrainLast    = TCW'(TRAIN_WORDS - 1);
    localparam logic [MaxPayload-1:0] TrainPayFull = train_payload(DWIDTH);
    localparam logic [PWIDTH-1:0]     IdleWord     = '0;
    localparam logic [PWIDTH-1:0]     TrainWord    =
        {TypeTrain, {CHW{1'b0}}, TrainPayFull[DWIDTH-1:0]};

    link_state_e       state_q;
    logic [LCW-1:0]    lock_cnt_q;
    logic [TCW-1:0]    train_cnt_q;
    logic [CHW-1:0]    ptr_q;
    logic [PWIDTH-1:0] pdata_q;

    logic [NREQ-1:0]   req_eff;
    logic [NREQ-1:0]   gnt;
    logic              gnt_any;
    logic [CHW-1:0]    gnt_idx;
    logic [PWIDTH-1:0] data_word;

    // Grants are withheld on a retrain cycle: the next word is a TRAIN word,
    // so an accepted payload would be dropped.
    always_comb begin
        req_eff = '0;
        if (state_q == StRun && i_plock && !i_retrain) begin
            req_eff = i_req_valid;
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req (req_eff),
        .i_ptr (ptr_q),
        .o_gnt (gnt)
    );

    always_comb begin
        gnt_any = |gnt;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_idx = CHW'(k);
            end
        end
        data_word = {TypeData, gnt_idx, i_req_data[gnt_idx*DWIDTH +: DWIDTH]};
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StWaitLock;
            lock_cnt_q  <= '0;
            train_cnt_q <= '0;
            ptr_q       <= '0;
            pdata_q     <= IdleWord;
        end else begin
            case (state_q)
                StWaitLock: begin
                    pdata_q     <= IdleWord;
                    train_cnt_q <= '0;
                    if (!i_plock) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LockLast) begin
                        state_q    <= StTrain;
                        lock_cnt_q <= '0;
                        pdata_q    <= TrainWord;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LCW'(1);
                    end
                end
                StTrain, StRun: begin
                    lock_cnt_q <= '0;
                    if (!i_plock) begin
                        state_q     <= StWaitLock;
                        train_cnt_q <= '0;
                        pdata_q     <= IdleWord;
                    end else if (i_retrain) begin
                        state_q     <= StTrain;
                        train_cnt_q <= '0;
                        pdata_q     <= TrainWord;
                    end else if (state_q == StTrain) begin
                        if (train_cnt_q == TrainLast) begin
                            state_q     <= StRun;
                            train_cnt_q <= '0;
                            pdata_q     <= IdleWord;
                        end else begin
                            train_cnt_q <= train_cnt_q + TCW'(1);
                            pdata_q     <= TrainWord;
                        end
                    end else if (gnt_any) begin
                        pdata_q <= data_word;
                        ptr_q   <= (gnt_idx == CHW'(NREQ - 1)) ? '0 : gnt_idx + CHW'(1);
                    end else begin
                        pdata_q <= IdleWord;
                    end
                end
                default: begin
                    state_q     <= StWaitLock;
                    lock_cnt_q  <= '0;
                    train_cnt_q <= '0;
                    pdata_q     <= IdleWord;
                end
            endcase
        end
    end

    assign o_req_ready = gnt;
    assign o_pdata     = pdata_q;
    assign o_state     = state_q;
    assign o_link_up   = (state_q == StRun);

endmodule
